// File: rtl/mux_b_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_b_pipe: registered operand-B select with a valid/ready 2-entry skid. |
// | Optional: MUX_B_SEL_ERR_EN adds a sticky sel_err output.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_b_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int IMM_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [IMM_W-1:0]         imm,
  input  logic                     imm_sext,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src
`ifdef MUX_B_SEL_ERR_EN
  ,
  output logic                     sel_err
`endif
);

  localparam logic [SEL_W-1:0] c_imm_sel = SEL_W'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_transfer;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic [WIDTH-1:0]  w_imm_ext;
  logic [WIDTH-1:0]  w_sel_data;
  logic [WIDTH-1:0]  r_main_data;
  logic [SEL_W-1:0]  r_main_src;
  logic [WIDTH-1:0]  r_skid_data;
  logic [SEL_W-1:0]  r_skid_src;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready   = !rst && (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main_data;
  assign out_src    = r_main_src;
  assign w_accept   = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;

  generate
    if (IMM_W < WIDTH) begin : g_imm_ext
      assign w_imm_ext = {{(WIDTH-IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
    end else begin : g_imm_full
      assign w_imm_ext = imm;
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = src_data[k*WIDTH +: WIDTH];
    end
    if (sel == c_imm_sel) w_sel_data = w_imm_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = ST_HALF;
        end
      end
      ST_HALF: begin
        if (w_accept && w_transfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_transfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_transfer) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = ST_HALF;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Main stays put on a bare transfer so EMPTY shows the last operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_src  <= '0;
      r_skid_data <= '0;
      r_skid_src  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= w_sel_data;
        r_main_src  <= sel;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_src  <= r_skid_src;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_src  <= sel;
      end
    end
  end

`ifdef MUX_B_SEL_ERR_EN
  logic r_sel_err;
  assign sel_err = r_sel_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_sel_err <= 1'b0;
    else if (w_accept && sel > c_imm_sel) r_sel_err <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_b_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_b_pipe: directed + random bench against a bounded-queue model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mux_b_pipe;
  localparam int WIDTH   = 16;
  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int IMM_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s [3];
  logic [47:0] src_data;
  logic [7:0]  imm;
  logic        imm_sext;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_src;

  always #5 clk = ~clk;
  assign src_data = {s[2], s[1], s[0]};

  mux_b_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .IMM_W(IMM_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .imm(imm), .imm_sext(imm_sext), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src)
`ifdef MUX_B_SEL_ERR_EN
    , .sel_err()
`endif
  );

`ifdef MUX_B_SEL_ERR_EN
  logic        e_rst, e_in_valid, e_in_ready, e_sext, e_out_valid, e_out_ready, e_sel_err;
  logic [31:0] e_src;
  logic [7:0]  e_imm;
  logic [1:0]  e_sel, e_out_src;
  logic [15:0] e_out_data;

  mux_b_pipe #(.WIDTH(16), .NUM_SRC(2), .SEL_W(2), .IMM_W(8)) u_err (
    .clk(clk), .rst(e_rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .src_data(e_src), .imm(e_imm), .imm_sext(e_sext), .sel(e_sel),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
    .out_src(e_out_src), .sel_err(e_sel_err)
  );
`endif

  typedef struct {
    logic [15:0] data;
    logic [1:0]  src;
  } op_t;

  op_t         q[$];
  logic [15:0] last;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Operand value straight from the selection rules.
  function automatic logic [15:0] ref_operand(input logic [1:0] sl, input logic [7:0] im,
                                              input logic sx);
    int v;
    if (sl < NUM_SRC) return s[sl];
    if (sl == NUM_SRC) begin
      v = im;
      if (sx && im >= 128) v = v - 256;
      return 16'(v);
    end
    return 16'h0000;
  endfunction

  // Depth-2 FIFO view: pop on transfer, then push on accept.
  task automatic model_edge();
    bit acc, xf;
    op_t e;
    acc = in_valid && (q.size() < 2) && !rst;
    xf  = (q.size() > 0) && out_ready;
    if (xf) begin
      last = q[0].data;
      void'(q.pop_front());
    end
    if (acc) begin
      e.data = ref_operand(sel, imm, imm_sext);
      e.src  = sel;
      q.push_back(e);
    end
  endtask

  task automatic compare(input string ph);
    check({ph, "/out_valid"}, out_valid, q.size() > 0);
    check({ph, "/in_ready"}, in_ready, q.size() < 2);
    if (q.size() > 0) begin
      check({ph, "/out_data"}, out_data, q[0].data);
      check({ph, "/out_src"}, out_src, q[0].src);
    end else begin
      check({ph, "/idle_data"}, out_data, last);
    end
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare(ph);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; imm = 8'h00; imm_sext = 1'b0;
    s[0] = 16'h1234; s[1] = 16'h4321; s[2] = 16'hABCD;
    last = 16'h0000;
`ifdef MUX_B_SEL_ERR_EN
    e_rst = 1'b1; e_in_valid = 1'b0; e_out_ready = 1'b1; e_sext = 1'b0;
    e_src = {16'h4321, 16'h1234}; e_imm = 8'h00; e_sel = 2'd0;
`endif
    #12;
    check("reset/out_valid", out_valid, 1'b0);
    check("reset/in_ready", in_ready, 1'b0);
    check("reset/out_data", out_data, 16'h0000);
    check("reset/out_src", out_src, 2'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("release/in_ready", in_ready, 1'b1);

    // Back-to-back sources.
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 2'd0; cycle("b2b0"); check("b2b0/const", out_data, 16'h1234);
    sel = 2'd1; cycle("b2b1"); check("b2b1/const", out_data, 16'h4321);
    sel = 2'd2; cycle("b2b2"); check("b2b2/const", out_data, 16'hABCD);
    check("b2b2/src", out_src, 2'd2);
    in_valid = 1'b0; cycle("b2b_idle");

    // Immediate extension.
    in_valid = 1'b1; sel = 2'd3; imm = 8'hF0; imm_sext = 1'b1;
    cycle("imm_s"); check("imm_s/const", out_data, 16'hFFF0);
    imm_sext = 1'b0;
    cycle("imm_z"); check("imm_z/const", out_data, 16'h00F0);
    in_valid = 1'b0; cycle("imm_idle");

    // Backpressure into the skid.
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd0; cycle("bp0");
    sel = 2'd1; cycle("bp1"); check("bp1/in_ready", in_ready, 1'b0);
    sel = 2'd2; cycle("bp2"); check("bp2/const", out_data, 16'h1234);
    out_ready = 1'b1;
    cycle("bp_drain0"); check("bp_drain0/const", out_data, 16'h4321);
    cycle("bp_drain1"); check("bp_drain1/const", out_data, 16'hABCD);
    in_valid = 1'b0;
    cycle("bp_drain2"); check("bp_drain2/empty", out_valid, 1'b0);

    // Hold stability while sources toggle.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; cycle("hold_load");
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s[0] = ~s[0]; s[1] = ~s[1]; s[2] = ~s[2];
      cycle("hold");
      check("hold/const", out_data, 16'h4321);
    end
    s[0] = 16'h1234; s[1] = 16'h4321; s[2] = 16'hABCD;

    // Async reset while FULL.
    in_valid = 1'b1; sel = 2'd0; cycle("fill");
    check("fill/in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    q.delete(); last = 16'h0000;
    check("arst/out_valid", out_valid, 1'b0);
    check("arst/out_data", out_data, 16'h0000);
    check("arst/in_ready", in_ready, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    check("arst_rel/in_ready", in_ready, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1;
    cycle("post_rst"); check("post_rst/const", out_data, 16'h4321);
    in_valid = 1'b0; cycle("post_rst_idle");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom);
      imm       = 8'($urandom);
      imm_sext  = 1'($urandom);
      s[0] = 16'($urandom); s[1] = 16'($urandom); s[2] = 16'($urandom);
      cycle("rand");
    end

`ifdef MUX_B_SEL_ERR_EN
    e_rst = 1'b0; #1;
    check("err/reset", e_sel_err, 1'b0);
    e_in_valid = 1'b1; e_sel = 2'd3;
    @(posedge clk); #1;
    check("err/oor_data", e_out_data, 16'h0000);
    check("err/set", e_sel_err, 1'b1);
    e_sel = 2'd0;
    @(posedge clk); #1;
    check("err/src0", e_out_data, 16'h1234);
    check("err/sticky0", e_sel_err, 1'b1);
    e_sel = 2'd2; e_imm = 8'hF0; e_sext = 1'b1;
    @(posedge clk); #1;
    check("err/imm", e_out_data, 16'hFFF0);
    check("err/sticky1", e_sel_err, 1'b1);
    e_in_valid = 1'b0; e_rst = 1'b1; #1;
    check("err/clear", e_sel_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
